// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multi-cycle RISC-style datapath. The instruction flow is
//   FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH. A memory wait that is too
//   long, or an unknown opcode, sends the FSM to TRAP. It stays there until
//   reset.
//
//   Parameter
//     MEM_TIMEOUT  maximum cycles a memory request waits for MEM_ACK (1..255)
//
//   Ports
//     CLK       clock, rising edge
//     RST       synchronous active-high reset
//     OPCODE    IR[6:0], sampled in DECODE
//     BR_TAKEN  branch compare result, sampled in EXEC
//     MEM_ACK   memory completion strobe (ignored unless MEM_REQ=1)
//     MEM_REQ   memory request level      MEM_WE   store qualifier
//     IR_WE     instruction-register load RF_RE    register-file read enable
//     RF_WE     register-file write       ALU_SRC  0=B operand, 1=IMM
//     WB_SEL    00 ALU, 01 mem, 10 PC+4   PC_WE    PC update pulse
//     PC_SRC    00 PC+4, 01 branch, 10 jump
//     STATE     current state (debug)     ERR      trap indicator
//     RETIRED   retired-instruction count (only with the macro below)
//
//   Optional feature: define MULTICYCLE_CTRL_RETIRE_CNT_EN to add the 32-bit
//   RETIRED counter output.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  OPCODE,
    input  logic        BR_TAKEN,
    input  logic        MEM_ACK,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        IR_WE,
    output logic        RF_RE,
    output logic        RF_WE,
    output logic        ALU_SRC,
    output logic [1:0]  WB_SEL,
    output logic        PC_WE,
    output logic [1:0]  PC_SRC,
    output logic [2:0]  STATE,
    output logic        ERR
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   ,output logic [31:0] RETIRED
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_R, C_I, C_L, C_S, C_B, C_J
    } cls_e;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    cls_e       cls_q,   cls_d;
    logic       taken_q, taken_d;
    logic [7:0] wait_q,  wait_d;
    logic [7:0] wait_inc;

    // Unmasked Moore outputs; reset masking is applied at the ports.
    logic       req, mwe, irwe, rfre, rfwe, asrc, pcwe, err;
    logic [1:0] wbs, pcs;

    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        taken_d = taken_q;
        wait_d  = '0;      // cleared whenever not waiting, so FETCH/MEM start at 0
        req     = 1'b0;
        mwe     = 1'b0;
        irwe    = 1'b0;
        rfre    = 1'b0;
        rfwe    = 1'b0;
        asrc    = 1'b0;
        pcwe    = 1'b0;
        err     = 1'b0;
        wbs     = 2'b00;
        pcs     = 2'b00;

        case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (MEM_ACK) begin
                    irwe    = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    // An acknowledge in the limit cycle wins over the timeout.
                    wait_d = wait_inc;
                    if (wait_inc >= TMO) state_d = S_TRAP;
                end
            end

            S_DECODE: begin
                rfre    = 1'b1;
                state_d = S_EXEC;
                case (OPCODE)
                    7'b0110011: cls_d = C_R;
                    7'b0010011: cls_d = C_I;
                    7'b0000001: cls_d = C_L;
                    7'b0100011: cls_d = C_S;
                    7'b1100011: cls_d = C_B;
                    7'b1101111: cls_d = C_J;
                    default:    state_d = S_TRAP;
                endcase
            end

            S_EXEC: begin
                asrc = (cls_q == C_I) || (cls_q == C_L) || (cls_q == C_S);
                if (cls_q == C_B) taken_d = BR_TAKEN;
                state_d = ((cls_q == C_L) || (cls_q == C_S)) ? S_MEM : S_WB;
            end

            S_MEM: begin
                req = 1'b1;
                mwe = (cls_q == C_S);
                if (MEM_ACK) begin
                    state_d = S_WB;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc >= TMO) state_d = S_TRAP;
                end
            end

            S_WB: begin
                pcwe    = 1'b1;
                rfwe    = (cls_q == C_R) || (cls_q == C_I) ||
                          (cls_q == C_L) || (cls_q == C_J);
                wbs     = (cls_q == C_L) ? 2'b01 :
                          (cls_q == C_J) ? 2'b10 : 2'b00;
                pcs     = ((cls_q == C_B) && taken_q) ? 2'b01 :
                          (cls_q == C_J)              ? 2'b10 : 2'b00;
                state_d = S_FETCH;
            end

            S_TRAP: begin
                err = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            cls_q   <= C_R;
            taken_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            taken_q <= taken_d;
            wait_q  <= wait_d;
        end
    end

    // Reset is synchronous, so the register may still hold a pre-reset state
    // during the RST cycle; outputs are forced quiet combinationally.
    always_comb begin
        MEM_REQ = req  & ~RST;
        MEM_WE  = mwe  & ~RST;
        IR_WE   = irwe & ~RST;
        RF_RE   = rfre & ~RST;
        RF_WE   = rfwe & ~RST;
        ALU_SRC = asrc & ~RST;
        PC_WE   = pcwe & ~RST;
        ERR     = err  & ~RST;
        WB_SEL  = RST ? 2'b00 : wbs;
        PC_SRC  = RST ? 2'b00 : pcs;
        STATE   = RST ? 3'd0  : state_q;
    end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    assign retired_d = (state_q == S_WB) ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge CLK) begin
        if (RST) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign RETIRED = RST ? '0 : retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl: a per-cycle table of inputs and
//   expected outputs, followed by hand-written timeout, reset and (optional)
//   retire-counter sequences. Inputs change on the falling edge and outputs
//   are compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000001;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_X = 7'b1111111;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [6:0]  OPCODE = '0;
    logic        BR_TAKEN = 1'b0;
    logic        MEM_ACK = 1'b0;
    logic        MEM_REQ, MEM_WE, IR_WE, RF_RE, RF_WE, ALU_SRC, PC_WE, ERR;
    logic [1:0]  WB_SEL, PC_SRC;
    logic [2:0]  STATE;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] RETIRED;
`endif

    int n_vec = 0;
    int n_err = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .OPCODE  (OPCODE),
        .BR_TAKEN(BR_TAKEN),
        .MEM_ACK (MEM_ACK),
        .MEM_REQ (MEM_REQ),
        .MEM_WE  (MEM_WE),
        .IR_WE   (IR_WE),
        .RF_RE   (RF_RE),
        .RF_WE   (RF_WE),
        .ALU_SRC (ALU_SRC),
        .WB_SEL  (WB_SEL),
        .PC_WE   (PC_WE),
        .PC_SRC  (PC_SRC),
        .STATE   (STATE),
        .ERR     (ERR)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
       ,.RETIRED (RETIRED)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [6:0]  opc;
        logic        br;
        logic        ack;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Packed view: {STATE, ERR, MEM_REQ, MEM_WE, IR_WE, RF_RE, RF_WE,
    //               ALU_SRC, WB_SEL, PC_WE, PC_SRC}
    function automatic logic [14:0] e(input logic [2:0] st, input logic err,
                                      input logic req, input logic mwe,
                                      input logic irwe, input logic rfre,
                                      input logic rfwe, input logic asrc,
                                      input logic [1:0] wbs, input logic pcwe,
                                      input logic [1:0] pcs);
        return {st, err, req, mwe, irwe, rfre, rfwe, asrc, wbs, pcwe, pcs};
    endfunction

    function automatic logic [14:0] eZ();
        return e(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [14:0] eF(input logic irwe);
        return e(3'd0, 0, 1, 0, irwe, 0, 0, 0, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [14:0] eD();
        return e(3'd1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [14:0] eX(input logic asrc);
        return e(3'd2, 0, 0, 0, 0, 0, 0, asrc, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [14:0] eM(input logic mwe);
        return e(3'd3, 0, 1, mwe, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    endfunction
    function automatic logic [14:0] eW(input logic rfwe, input logic [1:0] wbs,
                                       input logic [1:0] pcs);
        return e(3'd4, 0, 0, 0, 0, 0, rfwe, 0, wbs, 1, pcs);
    endfunction
    function automatic logic [14:0] eT();
        return e(3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    endfunction

    function automatic logic [14:0] got();
        return {STATE, ERR, MEM_REQ, MEM_WE, IR_WE, RF_RE, RF_WE,
                ALU_SRC, WB_SEL, PC_WE, PC_SRC};
    endfunction

    task automatic add(input logic rst, input logic [6:0] opc, input logic br,
                       input logic ack, input logic [14:0] exp);
        vec_t v;
        v.rst = rst;
        v.opc = opc;
        v.br  = br;
        v.ack = ack;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [14:0] exp);
        n_vec++;
        if (got() !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%0d bits=%b, expected st=%0d bits=%b",
                     nm, got() >> 12, got()[11:0], exp >> 12, exp[11:0]);
        end
    endtask

    // Drive one cycle of inputs, compare, and advance to the next falling edge.
    task automatic step(input logic rst, input logic [6:0] opc, input logic br,
                        input logic ack, input logic [14:0] exp, input string nm);
        RST      = rst;
        OPCODE   = opc;
        BR_TAKEN = br;
        MEM_ACK  = ack;
        #1;
        chk(nm, exp);
        @(negedge CLK);
    endtask

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    task automatic chk32(input string nm, input logic [31:0] exp);
        n_vec++;
        if (RETIRED !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, RETIRED, exp);
        end
    endtask

    task automatic run_r();
        step(0, OP_R, 0, 1, eF(1), "ret_fetch");
        step(0, OP_R, 0, 0, eD(), "ret_decode");
        step(0, OP_X, 0, 0, eX(0), "ret_exec");
        step(0, OP_X, 0, 0, eW(1, 2'b00, 2'b00), "ret_wb");
    endtask
`endif

    initial begin
        // Reset: every output 0, STATE 0.
        add(1, OP_I, 0, 1, eZ());
        add(1, OP_I, 0, 1, eZ());
        // I-type with MEM_ACK held high.
        add(0, OP_I, 0, 1, eF(1));
        add(0, OP_I, 0, 1, eD());
        add(0, OP_X, 0, 1, eX(1));
        add(0, OP_X, 0, 1, eW(1, 2'b00, 2'b00));
        // Load with three wait cycles in MEM.
        add(0, OP_X, 0, 1, eF(1));
        add(0, OP_L, 0, 0, eD());
        add(0, OP_X, 0, 0, eX(1));
        add(0, OP_X, 0, 0, eM(0));
        add(0, OP_X, 0, 0, eM(0));
        add(0, OP_X, 0, 0, eM(0));
        add(0, OP_X, 0, 1, eM(0));
        add(0, OP_X, 0, 0, eW(1, 2'b01, 2'b00));
        // Store, no waits.
        add(0, OP_X, 0, 1, eF(1));
        add(0, OP_S, 0, 0, eD());
        add(0, OP_X, 0, 0, eX(1));
        add(0, OP_X, 0, 1, eM(1));
        add(0, OP_X, 0, 0, eW(0, 2'b00, 2'b00));
        // Branch taken; BR_TAKEN drops in WB and must not matter.
        add(0, OP_X, 0, 1, eF(1));
        add(0, OP_B, 0, 0, eD());
        add(0, OP_X, 1, 0, eX(0));
        add(0, OP_X, 0, 0, eW(0, 2'b00, 2'b01));
        // Branch not taken; BR_TAKEN rises in WB and must not matter.
        add(0, OP_X, 1, 1, eF(1));
        add(0, OP_B, 1, 0, eD());
        add(0, OP_X, 0, 0, eX(0));
        add(0, OP_X, 1, 0, eW(0, 2'b00, 2'b00));
        // Jump.
        add(0, OP_X, 0, 1, eF(1));
        add(0, OP_J, 0, 0, eD());
        add(0, OP_X, 0, 0, eX(0));
        add(0, OP_X, 0, 0, eW(1, 2'b10, 2'b10));
        // R-type with one fetch wait cycle.
        add(0, OP_X, 0, 0, eF(0));
        add(0, OP_X, 0, 1, eF(1));
        add(0, OP_R, 0, 0, eD());
        add(0, OP_X, 0, 0, eX(0));
        add(0, OP_X, 0, 0, eW(1, 2'b00, 2'b00));
        // Illegal opcode traps; ACK in TRAP ignored; reset recovers.
        add(0, OP_X, 0, 1, eF(1));
        add(0, OP_X, 0, 1, eD());
        add(0, OP_X, 0, 1, eT());
        add(0, OP_R, 0, 1, eT());
        add(1, OP_R, 0, 1, eZ());
        add(0, OP_R, 0, 0, eF(0));

        @(negedge CLK);
        for (int unsigned i = 0; i < unsigned'(tbl.size()); i++)
            step(tbl[i].rst, tbl[i].opc, tbl[i].br, tbl[i].ack, tbl[i].exp,
                 $sformatf("tbl[%0d]", i));

        // FETCH timeout: 15 unacknowledged request cycles, then TRAP.
        step(1, OP_R, 0, 0, eZ(), "tmo_rst");
        for (int unsigned i = 0; i < 15; i++)
            step(0, OP_R, 0, 0, eF(0), $sformatf("fetch_wait[%0d]", i));
        step(0, OP_R, 0, 1, eT(), "fetch_tmo_trap");
        step(0, OP_R, 0, 1, eT(), "trap_held");

        // ACK in the limit cycle beats the timeout.
        step(1, OP_R, 0, 0, eZ(), "lim_rst");
        for (int unsigned i = 0; i < 14; i++)
            step(0, OP_R, 0, 0, eF(0), $sformatf("lim_wait[%0d]", i));
        step(0, OP_R, 0, 1, eF(1), "lim_ack");
        step(0, OP_L, 0, 0, eD(), "lim_decode");

        // Reset while a load request is outstanding.
        step(0, OP_X, 0, 0, eX(1), "mrst_exec");
        step(0, OP_X, 0, 0, eM(0), "mrst_mem0");
        step(0, OP_X, 0, 0, eM(0), "mrst_mem1");
        step(1, OP_X, 0, 0, eZ(), "mrst_rst");
        step(0, OP_X, 0, 0, eF(0), "mrst_fetch");

        // MEM timeout on a store.
        step(0, OP_X, 0, 1, eF(1), "mtmo_fetch");
        step(0, OP_S, 0, 0, eD(), "mtmo_decode");
        step(0, OP_X, 0, 0, eX(1), "mtmo_exec");
        for (int unsigned i = 0; i < 15; i++)
            step(0, OP_X, 0, 0, eM(1), $sformatf("mem_wait[%0d]", i));
        step(0, OP_X, 0, 1, eT(), "mem_tmo_trap");

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        step(1, OP_R, 0, 0, eZ(), "ret_rst");
        chk32("ret_zero", 32'd0);
        run_r();
        run_r();
        run_r();
        chk32("ret_three", 32'd3);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        chk32("ret_preload", 32'hFFFF_FFFF);
        run_r();
        chk32("ret_wrap", 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of cycles MEM_REQ SHALL wait for MEM_ACK before trapping (valid range 1..255).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 OPCODE  input  7  IR[6:0] of the instruction register; sampled in DECODE only.
REQ-005 BR_TAKEN  input  1  branch-compare result from ALU; sampled in EXEC only.
REQ-006 MEM_ACK  input  1  memory completion strobe for the current MEM_REQ.
REQ-007 MEM_REQ  output  1  memory request, level, held until acknowledged.
REQ-008 MEM_WE  output  1  store qualifier, valid while MEM_REQ=1.
REQ-009 IR_WE  output  1  instruction-register load pulse.
REQ-010 RF_RE  output  1  register-file read enable.
REQ-011 RF_WE  output  1  register-file write enable.
REQ-012 ALU_SRC  output  1  0 = B operand, 1 = IMM operand.
REQ-013 WB_SEL  output  2  00 ALU, 01 memory data, 10 PC+4.
REQ-014 PC_WE  output  1  PC update pulse.
REQ-015 PC_SRC  output  2  00 PC+4, 01 PC+IMM (taken branch), 10 PC+IMM (jump).
REQ-016 STATE  output  3  current state encoding, for debug.
REQ-017 ERR  output  1  sticky trap indicator.

Function
REQ-018 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all outputs are Moore functions of state plus the latched opcode class and latched taken flag.
REQ-019 FETCH: MEM_REQ=1, MEM_WE=0; on MEM_ACK=1, IR_WE=1 in that same cycle and next state DECODE; otherwise remain.
REQ-020 DECODE: RF_RE=1 for exactly one cycle; OPCODE latched into class R(0110011), I(0010011), L(0000001), S(0100011), B(1100011), J(1101111); any other value goes to TRAP, else to EXEC.
REQ-021 EXEC: one cycle; ALU_SRC=1 for I/L/S, 0 for R/B; BR_TAKEN latched into taken flag for B; next state MEM for L/S, WB otherwise.
REQ-022 MEM: MEM_REQ=1, MEM_WE=1 for S and 0 for L; on MEM_ACK go to WB.
REQ-023 WB: one cycle; PC_WE=1; RF_WE=1 for R/I/L/J only; WB_SEL=01 for L, 10 for J, 00 otherwise; PC_SRC=01 for B with taken flag set, 10 for J, 00 otherwise; next state FETCH.
REQ-024 Minimum latency SHALL be 4 cycles for R/I/B/J and 5 cycles for L/S (MEM_ACK in first request cycle); each extra wait cycle adds exactly one.
REQ-025 PC_WE SHALL pulse exactly once per completed instruction; IR_WE exactly once per fetch; neither SHALL assert in TRAP.
REQ-026 MEM_ACK while MEM_REQ=0 SHALL be ignored.
REQ-027 A wait counter SHALL clear on entering FETCH or MEM and increment each cycle without MEM_ACK; reaching MEM_TIMEOUT SHALL go to TRAP next cycle; MEM_ACK in the same cycle as the limit takes priority.
REQ-028 TRAP: ERR=1, all enables 0, MEM_REQ=0; state held until RST.

Reset
REQ-029 RST=1 at a clock edge SHALL force state FETCH, ERR=0, wait counter 0, taken flag 0, latched class R, regardless of current state, including mid-MEM with request outstanding.
REQ-030 While RST=1 all outputs SHALL be 0 except STATE=0; MEM_REQ SHALL first assert on the cycle after RST deasserts.

Configuration
REQ-031 Macro MULTICYCLE_CTRL_RETIRE_CNT_EN defined: adds output RETIRED (32 bits), reset to 0, incremented on each WB cycle, wraps 0xFFFFFFFF to 0.
REQ-032 Macro undefined: RETIRED port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset release, OPCODE=0010011, MEM_ACK held 1 -> states 0,1,2,4,0; RF_WE=1, ALU_SRC=1 seen in WB/EXEC; PC_WE once at cycle 4.
REQ-034 OPCODE=0000001, MEM_ACK low 3 cycles in MEM -> MEM held 4 cycles, MEM_WE=0, WB with WB_SEL=01, RF_WE=1.
REQ-035 OPCODE=1100011, BR_TAKEN=1 in EXEC then 0 in WB -> PC_SRC=01, RF_WE=0 in WB.
REQ-036 OPCODE=1111111 -> DECODE to TRAP, ERR=1, no further MEM_REQ until RST.
REQ-037 MEM_ACK never asserted in FETCH, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles; RST during MEM with request outstanding -> FETCH next cycle, ERR=0.
REQ-038 With MULTICYCLE_CTRL_RETIRE_CNT_EN, 3 instructions retired -> RETIRED=3; preload test wraps to 0.
